// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the RV32I pipeline control, including the memory wait-state encoding.
package rv32i_types;
  typedef enum logic [1:0] {RUN, WAIT_I, WAIT_D, WAIT_ID} wait_state_t;
  localparam logic [4:0] X0 = 5'd0;
endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational source/destination match producing the ID-stage data hazard bit.
module hazard_detect
  import rv32i_types::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_is_cmp,
  input  logic [4:0] ex_rd,
  input  logic       ex_load_regfile,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_is_load,
  output logic       hazard
);
  function automatic logic src_hazard(input logic [4:0] rs, input logic used);
    logic ex_hit, mem_hit;
    ex_hit  = rs == ex_rd;
    mem_hit = rs == mem_rd;
    return used && rs != X0 &&
           ((ex_hit && ex_is_load) ||
            (id_is_cmp && ((ex_hit && ex_load_regfile) || (mem_hit && mem_is_load))));
  endfunction

  always_comb hazard = src_hazard(id_rs1, id_uses_rs1) | src_hazard(id_rs2, id_uses_rs2);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline sequencing (memory freeze, data-hazard bubbles, ID redirects).
// Optional HAZARD_PERF_EN adds stall_cycles/flush_count performance counters.
module hazard_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_is_cmp,
  input  logic        id_redirect,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load_regfile,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_rd,
  input  logic        mem_is_load,
  input  logic        imem_req,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        bubble_id_ex,
  output logic        pc_redirect
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);
  wait_state_t state, state_nx;
  logic hazard, out_i, out_d, advance, run;

  hazard_detect u_detect (
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .id_is_cmp(id_is_cmp),
    .ex_rd(ex_rd),
    .ex_load_regfile(ex_load_regfile),
    .ex_is_load(ex_is_load),
    .mem_rd(mem_rd),
    .mem_is_load(mem_is_load),
    .hazard(hazard)
  );

  // A response seen while the other side is pending is remembered by moving to the single-side wait.
  always_comb begin
    out_i = imem_req & ~imem_resp;
    out_d = dmem_req & ~dmem_resp;
    state_nx = state == RUN    ? (out_i & out_d ? WAIT_ID : out_i ? WAIT_I : out_d ? WAIT_D : RUN)
             : state == WAIT_I ? (imem_resp ? RUN : WAIT_I)
             : state == WAIT_D ? (dmem_resp ? RUN : WAIT_D)
             : (imem_resp & dmem_resp ? RUN : imem_resp ? WAIT_D : dmem_resp ? WAIT_I : WAIT_ID);
    advance = state_nx == RUN;
    run = rst & advance;
    load_pc = run & ~hazard;
    load_if_id = run & ~hazard;
    load_id_ex = run;
    load_ex_mem = run;
    load_mem_wb = run;
    bubble_id_ex = run & hazard;
    pc_redirect = run & ~hazard & id_redirect;
    flush_if_id = run & ~hazard & id_redirect;
  end

  always_ff @(posedge clk)
    if (!rst) state <= RUN;
    else state <= state_nx;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk)
    if (!rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!advance || hazard) stall_cycles <= stall_cycles + 32'd1;
      if (pc_redirect) flush_count <= flush_count + 32'd1;
    end
`endif
endmodule
